div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Issue-side controller for the SRT-4 disparity divider (11-bit x, 11-bit d, sign flag f; 10-bit result {f, 8.1 quotient}).
- Accepts tagged divide requests over a valid/ready handshake, drives the divider's request pins, and times result capture from its own tag pipeline; the divider's valid output is never used.
- Buffers results in an output FIFO. Credit-based backpressure guarantees every issued request has a FIFO slot, so the divider never stalls.

Parameters:
- TAG_W, 8, width of the sideband tag carried with each request.
- LAT, 3, divider latency in clock edges from div_validin high to div_q valid.
- FIFO_DEPTH, 8, result FIFO entries; power of 2, must be >= LAT+2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_x  in  11  dividend.
- in_d  in  11  divisor.
- in_f  in  1  sign flag passed to divider.
- in_tag  in  TAG_W  request tag.
- div_clken  out  1  divider clock enable.
- div_validin  out  1  divider request strobe.
- div_x  out  11  divider dividend.
- div_d  out  11  divider divisor.
- div_f  out  1  divider sign flag.
- div_q  in  10  divider result.
- out_valid  out  1  result available (FIFO not empty).
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_q  out  10  result.
- out_tag  out  TAG_W  tag of the result.
- out_dz  out  1  divide-by-zero flag.

Behaviour:
Reset (rst=0 at a clk edge):
- in_ready=0, div_clken=0, div_validin=0, div_x=0, div_d=0, div_f=0, out_valid=0, out_q=0, out_tag=0, out_dz=0.
- inflight=0, FIFO emptied, tag pipe cleared.
- Reset mid-operation discards all in-flight and buffered results; none appear after release.

div_clken:
- Registered 1 from the first edge after reset release onward.
- The divider always advances; idle cycles are bubbles with div_validin=0.

Credit:
- inflight = accepted requests not yet written to the FIFO; fifo_cnt = FIFO occupancy.
- in_ready = rst_released & (inflight + fifo_cnt < FIFO_DEPTH), combinational from registers.
- A same-cycle FIFO pop is not credited.

Issue stage:
- On accept at edge E0, the block registers div_x=in_x, div_d=in_d, div_f=in_f, and div_validin=1 for exactly one cycle.
- Without accept: div_validin=0, and div_x/div_d/div_f hold their last values.
- The divider samples x and f every cycle, so these must stay stable between requests.
- Back-to-back accepts give consecutive div_validin pulses, one request per clock at full rate.

Tag pipe:
- A LAT-stage shift register holding {valid, tag, dz}, with dz=(in_d==0), loaded at E0 and shifting every clock.
- The stage-LAT entry coincides with div_q updated at edge E0+LAT.
- In that cycle the block samples div_q and writes {q, tag, dz} into the FIFO at edge E0+LAT+1.
- That same edge decrements inflight.

Result rules:
- dz=1: stored q = {f, 9'h1FF}; div_q is ignored.
- dz=0: stored q = div_q unchanged, including the x==0 case where the divider returns 10'd0 with sign dropped.

Latency and counters:
- out_valid rises after edge E0+LAT+1 (4 edges for LAT=3) when the FIFO was empty.
- Accept and FIFO write in the same cycle: inflight unchanged.

FIFO:
- Registered-output, show-ahead: out_q/out_tag/out_dz present the head entry whenever out_valid=1.
- Simultaneous write and pop when full cannot occur, because credit prevents it.
- Simultaneous write and pop when fifo_cnt=1: the head advances to the new entry and out_valid stays 1.
- Read and write pointers wrap modulo FIFO_DEPTH.
- Results leave in issue order.

Test Plan:
1. Single request x=100, d=7, f=1, tag=8'h5A, with a bench divider model of LAT=3 returning div_q=10'h21C at the expected cycle. Required: div_validin pulses 1 cycle after accept; out_valid rises 4 edges after accept with out_q=10'h21C, out_tag=8'h5A, out_dz=0.
2. Divide by zero: x=50, d=0, f=0, tag=3. Required: out_q=10'h1FF, out_dz=1, tag=3, and div_q is ignored even when the model drives 10'h000.
3. Stream of 20 back-to-back requests with out_ready=1 and tags 0..19. Required: in_ready stays 1 throughout; 20 results emerge in tag order 0..19 at one per clock; no drops.
4. out_ready=0 with continuous in_valid. Required: exactly 8 requests accepted, in_ready drops with inflight+fifo_cnt=8, and no FIFO overflow. Then raise out_ready: all 8 results drain in order, and in_ready re-asserts on the cycle after the first pop.
5. Reset asserted 2 cycles after accepting 3 requests, then released. Required: outputs at reset values; no stale out_valid in the following 10 cycles; in_ready=1 on the first cycle after release plus one.
6. Between requests, hold in_valid=0 for 5 cycles. Required: div_x/div_d/div_f are held stable, div_validin=0, and div_clken stays 1.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Issue-side controller for the SRT-4 divider: request handshake, fixed-latency
// result capture timed by a tag pipe, and a credit-protected result FIFO.
module div_issue_ctrl #(
  parameter int TAG_W      = 8,
  parameter int LAT        = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      in_x,
  input  logic [10:0]      in_d,
  input  logic             in_f,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_clken,
  output logic             div_validin,
  output logic [10:0]      div_x,
  output logic [10:0]      div_d,
  output logic             div_f,
  input  logic [9:0]       div_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_L = SW'(FIFO_DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             dz;
    logic             f;
  } tag_ent_t;

  typedef struct packed {
    logic [9:0]       q;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } res_ent_t;

  logic                      rst_released;
  logic [LAT:0]              vld_pipe;
  tag_ent_t [LAT:0]          ent_pipe;
  tag_ent_t                  new_ent;
  res_ent_t                  wr_ent;
  res_ent_t [FIFO_DEPTH-1:0] mem;
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [CW-1:0]             fifo_cnt;
  logic [CW-1:0]             inflight;
  logic [SW-1:0]             credit_used;
  logic                      accept;
  logic                      fifo_wr;
  logic                      fifo_rd;

  // Every accepted request owns a FIFO slot until it is popped, so the
  // divider can run free with no stall path back from the output.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign in_ready    = rst_released & (credit_used < DEPTH_L);
  assign accept      = in_valid & in_ready;
  assign fifo_wr     = vld_pipe[LAT];
  assign fifo_rd     = out_valid & out_ready;
  assign div_validin = vld_pipe[0];

  always_comb begin
    new_ent     = '0;
    new_ent.tag = in_tag;
    new_ent.dz  = (in_d == 11'd0);
    new_ent.f   = in_f;
  end

  // Divide-by-zero results are synthesized here; the divider output is ignored.
  always_comb begin
    wr_ent     = '0;
    wr_ent.q   = ent_pipe[LAT].dz ? {ent_pipe[LAT].f, 9'h1FF} : div_q;
    wr_ent.tag = ent_pipe[LAT].tag;
    wr_ent.dz  = ent_pipe[LAT].dz;
  end

  // Stage 0 is loaded on the accept edge; stage LAT lines up with div_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rst_released <= 1'b0;
      div_clken    <= 1'b0;
      div_x        <= '0;
      div_d        <= '0;
      div_f        <= 1'b0;
      vld_pipe     <= '0;
      ent_pipe     <= '0;
      inflight     <= '0;
    end else begin
      rst_released <= 1'b1;
      div_clken    <= 1'b1;
      vld_pipe     <= {vld_pipe[LAT-1:0], accept};
      ent_pipe     <= {ent_pipe[LAT-1:0], new_ent};
      // Operands hold between requests: the divider samples them every cycle.
      if (accept) begin
        div_x <= in_x;
        div_d <= in_d;
        div_f <= in_f;
      end
      case ({accept, fifo_wr})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) begin
        mem[wr_ptr] <= wr_ent;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Show-ahead head entry straight from the storage registers.
  assign out_valid = (fifo_cnt != '0);
  assign out_q     = mem[rd_ptr].q;
  assign out_tag   = mem[rd_ptr].tag;
  assign out_dz    = mem[rd_ptr].dz;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: LAT-cycle divider model, queue scoreboard with a
// credit/latency model, directed scenarios and a randomized traffic phase.
module tb_div_issue_ctrl;
  localparam int TAG_W = 8;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [10:0]      in_x = '0;
  logic [10:0]      in_d = '0;
  logic             in_f = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             div_clken;
  logic             div_validin;
  logic [10:0]      div_x;
  logic [10:0]      div_d;
  logic             div_f;
  logic [9:0]       div_q = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [9:0]       out_q;
  logic [TAG_W-1:0] out_tag;
  logic             out_dz;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [9:0]       q;
    logic [TAG_W-1:0] tag;
    logic             dz;
    int               rdy;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_issue_ctrl #(.TAG_W(TAG_W), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_d(in_d),
    .in_f(in_f), .in_tag(in_tag),
    .div_clken(div_clken), .div_validin(div_validin), .div_x(div_x),
    .div_d(div_d), .div_f(div_f), .div_q(div_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q),
    .out_tag(out_tag), .out_dz(out_dz)
  );

  // Divider model: {f, floor(2x/d)} in 8.1 format, x==0 -> 0, d==0 -> 0.
  function automatic logic [9:0] div_fn(input logic [10:0] x, input logic [10:0] d,
                                        input logic f);
    int unsigned t;
    if (d == 11'd0 || x == 11'd0) return 10'd0;
    t = (32'(x) * 2) / 32'(d);
    return {f, t[8:0]};
  endfunction

  function automatic logic [9:0] ref_result(input logic [10:0] x, input logic [10:0] d,
                                            input logic f);
    if (d == 11'd0) return {f, 9'h1FF};
    return div_fn(x, d, f);
  endfunction

  // Samples operands on the edge after div_validin rises, result LAT edges after.
  logic [9:0] s1 = '0;
  logic [9:0] s2 = '0;
  always @(posedge clk) begin
    s1    <= div_fn(div_x, div_d, div_f);
    s2    <= s1;
    div_q <= s2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: occupancy = accepted - popped; result visible LAT+1 edges after accept.
  task automatic monitor();
    int          ne = 0;
    int          acc = 0;
    int          pops = 0;
    logic        rel = 1'b0;
    logic        dv = 1'b0;
    logic [10:0] cx = '0;
    logic [10:0] cd = '0;
    logic        cf = 1'b0;
    logic        exp_ir;
    logic        exp_ov;
    exp_t        e;
    forever begin
      @(posedge clk);
      rel = rst;
      ne++;
      @(negedge clk);
      exp_ir = rel && ((acc - pops) < DEPTH);
      exp_ov = (sb.size() > 0) && (sb[0].rdy <= ne);
      n_cmp++;
      if (in_ready !== exp_ir) begin
        n_err++;
        $display("FAIL mon_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_ir);
      end
      n_cmp++;
      if (out_valid !== exp_ov) begin
        n_err++;
        $display("FAIL mon_out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_ov);
      end
      n_cmp++;
      if (div_validin !== dv) begin
        n_err++;
        $display("FAIL mon_div_validin t=%0t got=%b exp=%b", $time, div_validin, dv);
      end
      n_cmp++;
      if (div_clken !== rel) begin
        n_err++;
        $display("FAIL mon_div_clken t=%0t got=%b exp=%b", $time, div_clken, rel);
      end
      n_cmp++;
      if ({div_x, div_d, div_f} !== {cx, cd, cf}) begin
        n_err++;
        $display("FAIL mon_div_bus t=%0t got=%h/%h/%b exp=%h/%h/%b", $time,
                 div_x, div_d, div_f, cx, cd, cf);
      end
      if (!rst) begin
        sb.delete();
        acc = 0; pops = 0; dv = 1'b0;
        cx = '0; cd = '0; cf = 1'b0;
      end else begin
        dv = 1'b0;
        if (out_valid && out_ready) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL mon_pop t=%0t got=q%h/tag%h exp=no_entry", $time, out_q, out_tag);
          end else begin
            e = sb.pop_front();
            pops++;
            if ({out_q, out_tag, out_dz} !== {e.q, e.tag, e.dz}) begin
              n_err++;
              $display("FAIL mon_result t=%0t got=q%h tag%h dz%b exp=q%h tag%h dz%b",
                       $time, out_q, out_tag, out_dz, e.q, e.tag, e.dz);
            end
          end
        end
        if (in_valid && in_ready) begin
          e.q   = ref_result(in_x, in_d, in_f);
          e.tag = in_tag;
          e.dz  = (in_d == 11'd0);
          e.rdy = ne + 1 + LAT + 1;
          sb.push_back(e);
          acc++;
          dv = 1'b1;
          cx = in_x; cd = in_d; cf = in_f;
        end
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wait_ready got=%b exp=1 after %0d cycles", in_ready, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({in_ready, div_clken, div_validin, out_valid} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_ctl got=%b exp=0000", {in_ready, div_clken, div_validin, out_valid});
    end
    n_cmp++;
    if ({div_x, div_d, div_f} !== 23'd0) begin
      n_err++;
      $display("FAIL reset_div_bus got=%h/%h/%b exp=0", div_x, div_d, div_f);
    end
    n_cmp++;
    if ({out_q, out_tag, out_dz} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_out_bus got=%h/%h/%b exp=0", out_q, out_tag, out_dz);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({in_ready, div_clken} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_release got=%b exp=11", {in_ready, div_clken});
    end
  endtask

  task automatic test_single(input logic [10:0] x, input logic [10:0] d, input logic f,
                             input logic [7:0] tag, input logic [9:0] exp_q,
                             input logic exp_dz, input string nm);
    out_ready = 1'b0;
    wait_ready();
    in_valid = 1'b1; in_x = x; in_d = d; in_f = f; in_tag = tag;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({div_validin, div_x, div_d, div_f} !== {1'b1, x, d, f}) begin
      n_err++;
      $display("FAIL %s_issue got=%b/%h/%h/%b exp=1/%h/%h/%b", nm,
               div_validin, div_x, div_d, div_f, x, d, f);
    end
    step();
    n_cmp++;
    if (div_validin !== 1'b0) begin
      n_err++;
      $display("FAIL %s_pulse got=%b exp=0", nm, div_validin);
    end
    step();
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_early got=%b exp=0", nm, out_valid);
    end
    step();
    n_cmp++;
    if ({out_valid, out_q, out_tag, out_dz} !== {1'b1, exp_q, tag, exp_dz}) begin
      n_err++;
      $display("FAIL %s_result got=v%b q%h tag%h dz%b exp=v1 q%h tag%h dz%b", nm,
               out_valid, out_q, out_tag, out_dz, exp_q, tag, exp_dz);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_pop got=%b exp=0", nm, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   got = 0;
    logic gap = 1'b0;
    out_ready = 1'b1;
    wait_ready();
    for (int c = 0; c < 60; c++) begin
      if (out_valid) begin
        n_cmp++;
        if (out_tag !== 8'(got)) begin
          n_err++;
          $display("FAIL stream_order got=%h exp=%h", out_tag, 8'(got));
        end
        got++;
      end else if (got > 0 && got < 20) begin
        gap = 1'b1;
      end
      if (sent < 20) begin
        in_valid = 1'b1;
        in_tag   = 8'(sent);
        in_x     = 11'($urandom);
        in_d     = 11'($urandom_range(1, 2047));
        in_f     = 1'($urandom);
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL stream_in_ready got=%b exp=1 at req %0d", in_ready, sent);
        end
        if (in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    n_cmp++;
    if (got != 20 || sent != 20 || gap) begin
      n_err++;
      $display("FAIL stream_count got=%0d/%0d gap=%b exp=20/20 gap=0", sent, got, gap);
    end
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    int npop = 1;
    out_ready = 1'b0;
    wait_ready();
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_tag = 8'(100 + nacc);
      in_x   = 11'($urandom);
      in_d   = 11'($urandom_range(1, 2047));
      in_f   = 1'($urandom);
      if (in_ready) nacc++;
      step();
    end
    n_cmp++;
    if (nacc != DEPTH || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_fill got=acc%0d rdy%b ov%b exp=acc%0d rdy0 ov1",
               nacc, in_ready, out_valid, DEPTH);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_reassert got=%b exp=1", in_ready);
    end
    for (int i = 0; i < 15; i++) begin
      if (out_valid) npop++;
      step();
    end
    out_ready = 1'b0;
    n_cmp++;
    if (npop != DEPTH) begin
      n_err++;
      $display("FAIL bp_drain got=%0d exp=%0d", npop, DEPTH);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    wait_ready();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_tag = 8'(200 + i);
      in_x   = 11'($urandom);
      in_d   = 11'($urandom_range(1, 2047));
      step();
    end
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    n_cmp++;
    if ({in_ready, div_clken, div_validin, out_valid, div_x, div_d, div_f,
         out_q, out_tag, out_dz} !== '0) begin
      n_err++;
      $display("FAIL midrst_state got=rdy%b en%b vi%b ov%b x%h d%h q%h exp=all_zero",
               in_ready, div_clken, div_validin, out_valid, div_x, div_d, out_q);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_ready got=%b exp=1", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_stale got=%b exp=0 cycle %0d", out_valid, i);
      end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_idle_hold();
    out_ready = 1'b1;
    wait_ready();
    in_valid = 1'b1; in_x = 11'h3A5; in_d = 11'h011; in_f = 1'b1; in_tag = 8'd77;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (div_validin !== 1'b1) begin
      n_err++;
      $display("FAIL idle_issue got=%b exp=1", div_validin);
    end
    for (int i = 0; i < 5; i++) begin
      in_x = 11'($urandom); in_d = 11'($urandom); in_f = 1'($urandom);
      step();
      n_cmp++;
      if ({div_x, div_d, div_f, div_validin, div_clken} !== {11'h3A5, 11'h011, 1'b1, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL idle_hold got=%h/%h/%b vi%b en%b exp=3a5/011/1 vi0 en1",
                 div_x, div_d, div_f, div_validin, div_clken);
      end
    end
    in_valid = 1'b1; in_x = 11'h0FF; in_d = 11'h003; in_f = 1'b0; in_tag = 8'd78;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int acc_r = 0;
    int pop_r = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_x      = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom);
      in_d      = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom);
      in_f      = 1'($urandom);
      in_tag    = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      if (in_valid && in_ready) acc_r++;
      if (out_valid && out_ready) pop_r++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) pop_r++;
      step();
    end
    n_cmp++;
    if (pop_r != acc_r || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL random_drain got=pop%0d ov%b exp=pop%0d ov0", pop_r, out_valid, acc_r);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single(11'd100, 11'd7, 1'b1, 8'h5A, 10'h21C, 1'b0, "single");
    test_single(11'd50, 11'd0, 1'b0, 8'h03, 10'h1FF, 1'b1, "divzero");
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_idle_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
